// File: rtl/val2_shift_sequencer.sv
// Iterative Val2 shifter: an FSM steps a shift register one bit (or two for
// rotated immediates) per clock, yielding the operand, ARM carry-out and a stall.
module val2_shift_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] rm,
  input  logic [11:0]      shift_operand,
  input  logic             immd,
  input  logic             is_mem_command,
  input  logic             c_in,
  output logic [WIDTH-1:0] val2_out,
  output logic             carry_out,
  output logic             valid,
  output logic             busy,
  output logic             stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] M_LSL  = 3'd0;
  localparam logic [2:0] M_LSR  = 3'd1;
  localparam logic [2:0] M_ASR  = 3'd2;
  localparam logic [2:0] M_ROR  = 3'd3;
  localparam logic [2:0] M_ROR2 = 3'd4;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             cflag_q, cflag_d;
  logic [WIDTH-1:0] val2_q, val2_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             load_s;
  logic [WIDTH-1:0] load_acc_s;
  logic [2:0]       load_mode_s;
  logic [4:0]       load_n_s;

  // Decode the operand form captured at load time.
  always_comb begin
    load_s = (state_q == S_IDLE) && start && !flush;
    if (is_mem_command) begin
      load_acc_s  = {{(WIDTH-12){1'b0}}, shift_operand};
      load_mode_s = M_LSL;
      load_n_s    = 5'd0;
    end else if (immd) begin
      load_acc_s  = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
      load_mode_s = M_ROR2;
      load_n_s    = {1'b0, shift_operand[11:8]};
    end else begin
      load_acc_s  = rm;
      load_mode_s = {1'b0, shift_operand[6:5]};
      load_n_s    = shift_operand[11:7];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = (load_n_s != 5'd0) ? S_SHIFT : S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (cnt_q == 5'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Shift datapath: load on accepted start, one step per SHIFT cycle.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    cflag_d = cflag_q;
    if (load_s) begin
      acc_d   = load_acc_s;
      cnt_d   = load_n_s;
      mode_d  = load_mode_s;
      cflag_d = c_in;
    end else if ((state_q == S_SHIFT) && !flush) begin
      cnt_d = cnt_q - 5'd1;
      case (mode_q)
        M_LSL: begin
          cflag_d = acc_q[WIDTH-1];
          acc_d   = {acc_q[WIDTH-2:0], 1'b0};
        end
        M_LSR: begin
          cflag_d = acc_q[0];
          acc_d   = {1'b0, acc_q[WIDTH-1:1]};
        end
        M_ASR: begin
          cflag_d = acc_q[0];
          acc_d   = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        end
        M_ROR: begin
          cflag_d = acc_q[0];
          acc_d   = {acc_q[0], acc_q[WIDTH-1:1]};
        end
        M_ROR2: begin
          cflag_d = acc_q[1];
          acc_d   = {acc_q[1:0], acc_q[WIDTH-1:2]};
        end
        default: begin
          cflag_d = cflag_q;
          acc_d   = acc_q;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output logic: result and valid publish together as DONE retires.
  always_comb begin
    val2_d  = val2_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    busy_d  = (state_d == S_SHIFT);
    if ((state_q == S_DONE) && !flush) begin
      val2_d  = acc_q;
      carry_d = cflag_q;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= 5'd0;
      mode_q  <= 3'd0;
      cflag_q <= 1'b0;
      val2_q  <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cflag_q <= cflag_d;
      val2_q  <= val2_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign val2_out  = val2_q;
  assign carry_out = carry_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign stall     = busy_q;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Directed bench for val2_shift_sequencer with hand-computed results and latencies.
module tb_val2_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [31:0] rm;
  logic [11:0] shift_operand;
  logic        immd;
  logic        is_mem_command;
  logic        c_in;
  logic [31:0] val2_out;
  logic        carry_out;
  logic        valid;
  logic        busy;
  logic        stall;

  int chk_cnt = 0;
  int err_cnt = 0;

  val2_shift_sequencer #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .flush          (flush),
    .rm             (rm),
    .shift_operand  (shift_operand),
    .immd           (immd),
    .is_mem_command (is_mem_command),
    .c_in           (c_in),
    .val2_out       (val2_out),
    .carry_out      (carry_out),
    .valid          (valid),
    .busy           (busy),
    .stall          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation at a negedge and follow it to its valid pulse.
  task automatic run_op(input string tag, input logic [31:0] r, input logic [11:0] so,
                        input logic im, input logic mem, input logic ci,
                        input logic [31:0] exp_val, input logic exp_c,
                        input int exp_lat, input int exp_busy, input logic poke);
    int cyc;
    int busy_n;
    int stall_n;
    cyc = 0; busy_n = 0; stall_n = 0;
    rm = r; shift_operand = so; immd = im; is_mem_command = mem; c_in = ci;
    start = 1'b1;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke && cyc == 3) begin
        start = 1'b1; rm = 32'h1234_5678; shift_operand = 12'h000;
      end
      if (poke && cyc == 4) start = 1'b0;
      if (busy) busy_n++;
      if (stall) stall_n++;
      if (valid) break;
    end
    check_eq({tag, "_valid_seen"}, {31'd0, valid}, 32'd1);
    check_eq({tag, "_latency"}, cyc - 1, exp_lat);
    check_eq({tag, "_val2"}, val2_out, exp_val);
    check_eq({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
    check_eq({tag, "_busy_cycles"}, busy_n, exp_busy);
    check_eq({tag, "_stall_cycles"}, stall_n, exp_busy);
    @(negedge clk);
    check_eq({tag, "_valid_one_cycle"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; rm = 32'd0; shift_operand = 12'd0;
    immd = 1'b0; is_mem_command = 1'b0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_val2", val2_out, 32'd0);
    check_eq("reset_flags", {28'd0, carry_out, valid, busy, stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("lsl4",   32'h0000_0001, 12'h200, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 5, 4, 1'b0);
    run_op("asr4",   32'h8000_0000, 12'h240, 1'b0, 1'b0, 1'b1, 32'hF800_0000, 1'b0, 5, 4, 1'b0);
    run_op("ror1",   32'h0000_0001, 12'h0E0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 2, 1, 1'b0);
    run_op("imm103", 32'hDEAD_BEEF, 12'h103, 1'b1, 1'b0, 1'b0, 32'hC000_0000, 1'b1, 2, 1, 1'b0);
    run_op("imm0ff", 32'hDEAD_BEEF, 12'h0FF, 1'b1, 1'b0, 1'b0, 32'h0000_00FF, 1'b0, 1, 0, 1'b0);
    run_op("mem",    32'hDEAD_BEEF, 12'hABC, 1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 1'b1, 1, 0, 1'b0);
    run_op("lsr0",   32'h8000_0001, 12'h020, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 1'b0, 1, 0, 1'b0);
    run_op("lsr31",  32'hFFFF_FFFF, 12'hFA0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 32, 31, 1'b1);

    // Flush in the third SHIFT cycle of a 10-step LSL.
    rm = 32'h0000_0005; shift_operand = 12'h500; immd = 1'b0; is_mem_command = 1'b0;
    start = 1'b1;
    vcount = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 3) flush = 1'b1;
      if (i == 4) flush = 1'b0;
      if (valid) vcount++;
    end
    check_eq("flush_busy_dropped", {31'd0, busy}, 32'd0);
    check_eq("flush_no_valid", vcount, 32'd0);
    check_eq("flush_val2_kept", val2_out, 32'h0000_0001);
    check_eq("flush_carry_kept", {31'd0, carry_out}, 32'd1);
    run_op("after_flush", 32'h0000_0003, 12'h080, 1'b0, 1'b0, 1'b1, 32'h0000_0006, 1'b0, 2, 1, 1'b0);

    // Flush together with start in IDLE loads nothing.
    rm = 32'h0000_0007; shift_operand = 12'h100; start = 1'b1; flush = 1'b1;
    vcount = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      if (valid || busy) vcount++;
    end
    check_eq("flush_start_ignored", vcount, 32'd0);
    check_eq("flush_start_val2", val2_out, 32'h0000_0006);

    // Asynchronous reset in the middle of a shift.
    rm = 32'h0000_0001; shift_operand = 12'h500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_val2", val2_out, 32'd0);
    check_eq("async_reset_flags", {28'd0, carry_out, valid, busy, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_reset_ror2", 32'h0, 12'h4F0, 1'b1, 1'b0, 1'b0, 32'hF000_0000, 1'b1, 5, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
